// File: rtl/ccm_pkg.sv
// rtl/ccm_pkg.sv - shared widths, cfg addresses and reset bank for the colour-correction stage
package ccm_pkg;

    localparam int COEF_W = 12;
    localparam int FRAC   = 8;
    localparam int PROD_W = COEF_W + 9;
    localparam int SUM_W  = PROD_W + 2;

    localparam logic signed [COEF_W-1:0] COEF_ONE = COEF_W'(1) << FRAC;
    localparam logic signed [SUM_W-1:0]  ROUND    = SUM_W'(1) << (FRAC - 1);

    localparam logic [3:0] ADDR_C00    = 4'd0;
    localparam logic [3:0] ADDR_C01    = 4'd1;
    localparam logic [3:0] ADDR_C02    = 4'd2;
    localparam logic [3:0] ADDR_C10    = 4'd3;
    localparam logic [3:0] ADDR_C11    = 4'd4;
    localparam logic [3:0] ADDR_C12    = 4'd5;
    localparam logic [3:0] ADDR_C20    = 4'd6;
    localparam logic [3:0] ADDR_C21    = 4'd7;
    localparam logic [3:0] ADDR_C22    = 4'd8;
    localparam logic [3:0] ADDR_BYPASS = 4'd9;

    // Entry i holds coefficient C<row><col> with i = row*3 + col.
    typedef logic [8:0][COEF_W-1:0] bank_t;

    function automatic bank_t ident_bank();
        bank_t b;
        for (int i = 0; i < 9; i++) begin
            b[i] = (i % 4 == 0) ? COEF_ONE : '0;
        end
        return b;
    endfunction

    localparam bank_t IDENT_BANK = ident_bank();

endpackage

// File: rtl/ccm_channel.sv
// rtl/ccm_channel.sv - one output row: three products, rounded sum, clamp and bypass mux
module ccm_channel
    import ccm_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [7:0]               pix_r,
    input  logic [7:0]               pix_g,
    input  logic [7:0]               pix_b,
    input  logic [7:0]               pix_self,
    input  logic signed [COEF_W-1:0] coef_r,
    input  logic signed [COEF_W-1:0] coef_g,
    input  logic signed [COEF_W-1:0] coef_b,
    input  logic                     bypass,
    output logic [7:0]               data
);

    logic signed [PROD_W-1:0] prod_r, prod_g, prod_b;
    logic [7:0]               pix_dly;
    logic signed [SUM_W-1:0]  sum;
    logic signed [SUM_W-1:0]  shifted;
    logic [7:0]               clamped;

    function automatic logic signed [PROD_W-1:0] mul(input logic [7:0] p,
                                                    input logic signed [COEF_W-1:0] c);
        logic signed [PROD_W-1:0] pe;
        logic signed [PROD_W-1:0] ce;
        pe = {{(PROD_W-8){1'b0}}, p};
        ce = {{(PROD_W-COEF_W){c[COEF_W-1]}}, c};
        return pe * ce;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prod_r  <= '0;
            prod_g  <= '0;
            prod_b  <= '0;
            pix_dly <= '0;
        end else begin
            prod_r  <= mul(pix_r, coef_r);
            prod_g  <= mul(pix_g, coef_g);
            prod_b  <= mul(pix_b, coef_b);
            pix_dly <= pix_self;
        end
    end

    always_comb begin
        sum = {{2{prod_r[PROD_W-1]}}, prod_r}
            + {{2{prod_g[PROD_W-1]}}, prod_g}
            + {{2{prod_b[PROD_W-1]}}, prod_b}
            + ROUND;
        shifted = sum >>> FRAC;
        // Negative saturates to 0; any set bit above bit 7 saturates to 255.
        if (shifted[SUM_W-1]) begin
            clamped = 8'd0;
        end else if (|shifted[SUM_W-2:8]) begin
            clamped = 8'd255;
        end else begin
            clamped = shifted[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data <= '0;
        end else begin
            data <= bypass ? pix_dly : clamped;
        end
    end

endmodule

// File: rtl/ccm_top.sv
// rtl/ccm_top.sv - 3x3 colour-correction stage with frame-synchronous coefficient banks
module ccm_top
    import ccm_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_vsync,
    input  logic              in_hsync,
    input  logic              in_den,
    input  logic [7:0]        in_data_R,
    input  logic [7:0]        in_data_G,
    input  logic [7:0]        in_data_B,
    input  logic              cfg_we,
    input  logic [3:0]        cfg_addr,
    input  logic [COEF_W-1:0] cfg_wdata,
    output logic              cfg_pending,
    output logic              out_vsync,
    output logic              out_hsync,
    output logic              out_den,
    output logic [7:0]        out_data_R,
    output logic [7:0]        out_data_G,
    output logic [7:0]        out_data_B
);

    bank_t           stg_coef;
    bank_t           act_coef;
    logic            stg_bypass;
    logic            act_bypass;
    logic            vsync_prev;
    logic            commit;
    logic [7:0]      s1_r, s1_g, s1_b;
    logic [2:0][2:0] sync_sr;

    assign commit = in_vsync & ~vsync_prev;

    // Commit copies the pre-write staging content; a same-cycle write lands afterwards.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stg_coef    <= IDENT_BANK;
            act_coef    <= IDENT_BANK;
            stg_bypass  <= 1'b0;
            act_bypass  <= 1'b0;
            cfg_pending <= 1'b0;
            vsync_prev  <= 1'b0;
        end else begin
            vsync_prev <= in_vsync;
            if (commit) begin
                act_coef    <= stg_coef;
                act_bypass  <= stg_bypass;
                cfg_pending <= 1'b0;
            end
            if (cfg_we && (cfg_addr <= ADDR_BYPASS)) begin
                cfg_pending <= 1'b1;
                if (cfg_addr == ADDR_BYPASS) begin
                    stg_bypass <= cfg_wdata[0];
                end else begin
                    for (int i = 0; i < 9; i++) begin
                        if (cfg_addr == 4'(i)) begin
                            stg_coef[i] <= cfg_wdata;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_r    <= '0;
            s1_g    <= '0;
            s1_b    <= '0;
            sync_sr <= '0;
        end else begin
            s1_r    <= in_data_R;
            s1_g    <= in_data_G;
            s1_b    <= in_data_B;
            sync_sr <= {sync_sr[1:0], {in_vsync, in_hsync, in_den}};
        end
    end

    assign out_vsync = sync_sr[2][2];
    assign out_hsync = sync_sr[2][1];
    assign out_den   = sync_sr[2][0];

    ccm_channel u_row_r (
        .clk      (clk),
        .reset_n  (reset_n),
        .pix_r    (s1_r),
        .pix_g    (s1_g),
        .pix_b    (s1_b),
        .pix_self (s1_r),
        .coef_r   (act_coef[0]),
        .coef_g   (act_coef[1]),
        .coef_b   (act_coef[2]),
        .bypass   (act_bypass),
        .data     (out_data_R)
    );

    ccm_channel u_row_g (
        .clk      (clk),
        .reset_n  (reset_n),
        .pix_r    (s1_r),
        .pix_g    (s1_g),
        .pix_b    (s1_b),
        .pix_self (s1_g),
        .coef_r   (act_coef[3]),
        .coef_g   (act_coef[4]),
        .coef_b   (act_coef[5]),
        .bypass   (act_bypass),
        .data     (out_data_G)
    );

    ccm_channel u_row_b (
        .clk      (clk),
        .reset_n  (reset_n),
        .pix_r    (s1_r),
        .pix_g    (s1_g),
        .pix_b    (s1_b),
        .pix_self (s1_b),
        .coef_r   (act_coef[6]),
        .coef_g   (act_coef[7]),
        .coef_b   (act_coef[8]),
        .bypass   (act_bypass),
        .data     (out_data_B)
    );

endmodule

// File: tb/tb_ccm_top.sv
// tb/tb_ccm_top.sv - directed and randomized checks of ccm_top against a frame-level model
module tb_ccm_top;
    import ccm_pkg::*;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              in_vsync = 1'b0;
    logic              in_hsync = 1'b0;
    logic              in_den = 1'b0;
    logic [7:0]        in_data_R = '0;
    logic [7:0]        in_data_G = '0;
    logic [7:0]        in_data_B = '0;
    logic              cfg_we = 1'b0;
    logic [3:0]        cfg_addr = '0;
    logic [COEF_W-1:0] cfg_wdata = '0;
    logic              cfg_pending;
    logic              out_vsync, out_hsync, out_den;
    logic [7:0]        out_data_R, out_data_G, out_data_B;

    always #5 clk = ~clk;

    ccm_top dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_vsync    (in_vsync),
        .in_hsync    (in_hsync),
        .in_den      (in_den),
        .in_data_R   (in_data_R),
        .in_data_G   (in_data_G),
        .in_data_B   (in_data_B),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .cfg_pending (cfg_pending),
        .out_vsync   (out_vsync),
        .out_hsync   (out_hsync),
        .out_den     (out_den),
        .out_data_R  (out_data_R),
        .out_data_G  (out_data_G),
        .out_data_B  (out_data_B)
    );

    typedef struct packed {
        logic       vs;
        logic       hs;
        logic       den;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } exp_t;

    exp_t q[$];
    int   stg[10];
    int   act[10];
    bit   m_pending;
    bit   m_prev_vs;
    int   n_assert = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Index 9 of a bank holds the bypass flag.
    function automatic logic [7:0] row_val(input int row, input int r, input int g, input int b);
        int s;
        int v;
        s = r * act[row*3] + g * act[row*3+1] + b * act[row*3+2];
        v = (s + 128) >>> 8;
        if (v < 0) return 8'd0;
        if (v > 255) return 8'd255;
        return v[7:0];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 10; i++) stg[i] = (i < 9 && i % 4 == 0) ? 256 : 0;
        act = stg;
        m_pending = 0;
        m_prev_vs = 0;
        q.delete();
        q.push_back('0);
        q.push_back('0);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        e = '0;
        if (reset_n) begin
            if (in_vsync && !m_prev_vs) begin
                act = stg;
                m_pending = 0;
            end
            m_prev_vs = in_vsync;
            if (cfg_we && cfg_addr <= 4'd9) begin
                m_pending = 1;
                if (cfg_addr == 4'd9) stg[9] = int'(cfg_wdata[0]);
                else stg[cfg_addr] = int'($signed(cfg_wdata));
            end
            e.vs  = in_vsync;
            e.hs  = in_hsync;
            e.den = in_den;
            if (act[9] != 0) begin
                e.r = in_data_R;
                e.g = in_data_G;
                e.b = in_data_B;
            end else begin
                e.r = row_val(0, int'(in_data_R), int'(in_data_G), int'(in_data_B));
                e.g = row_val(1, int'(in_data_R), int'(in_data_G), int'(in_data_B));
                e.b = row_val(2, int'(in_data_R), int'(in_data_G), int'(in_data_B));
            end
            q.push_back(e);
            e = q.pop_front();
        end
        #1;
        chk("vsync", out_vsync, e.vs);
        chk("hsync", out_hsync, e.hs);
        chk("den", out_den, e.den);
        chk("pending", cfg_pending, m_pending);
        if (e.den) begin
            chk("model_R", out_data_R, e.r);
            chk("model_G", out_data_G, e.g);
            chk("model_B", out_data_B, e.b);
        end
    endtask

    task automatic drive(input bit vs, input bit hs, input bit den,
                         input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        in_vsync  = vs;
        in_hsync  = hs;
        in_den    = den;
        in_data_R = r;
        in_data_G = g;
        in_data_B = b;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 0, 8'($urandom), 8'($urandom), 8'($urandom));
            tick();
        end
    endtask

    task automatic wr(input logic [3:0] a, input int v);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = v[COEF_W-1:0];
        drive(0, 0, 0, 8'($urandom), 8'($urandom), 8'($urandom));
        tick();
        cfg_we = 1'b0;
    endtask

    // Vsync is held high for two cycles so a held-high level must not recommit.
    task automatic frame_edge(input bit we, input logic [3:0] a, input int v);
        idle(3);
        cfg_we    = we;
        cfg_addr  = a;
        cfg_wdata = v[COEF_W-1:0];
        drive(1, 0, 0, 8'($urandom), 8'($urandom), 8'($urandom));
        tick();
        cfg_we = 1'b0;
        drive(1, 0, 0, 8'($urandom), 8'($urandom), 8'($urandom));
        tick();
        idle(4);
    endtask

    task automatic px_expect(input string tag, input logic [7:0] r, input logic [7:0] g,
                             input logic [7:0] b, input logic [7:0] er, input logic [7:0] eg,
                             input logic [7:0] eb);
        drive(0, 1, 1, r, g, b);
        tick();
        idle(2);
        chk({tag, "_R"}, out_data_R, er);
        chk({tag, "_G"}, out_data_G, eg);
        chk({tag, "_B"}, out_data_B, eb);
        chk({tag, "_den"}, out_den, 1'b1);
    endtask

    initial begin
        model_reset();
        tick();
        tick();
        chk("rst_R", out_data_R, 8'd0);
        chk("rst_den", out_den, 1'b0);
        chk("rst_pending", cfg_pending, 1'b0);
        #2 reset_n = 1'b1;

        px_expect("ident", 8'd10, 8'd128, 8'd250, 8'd10, 8'd128, 8'd250);
        chk("ident_pending", cfg_pending, 1'b0);

        wr(ADDR_C00, 384);
        chk("c00_pending", cfg_pending, 1'b1);
        frame_edge(0, 4'd0, 0);
        px_expect("clamp_hi", 8'd200, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0);
        px_expect("gain", 8'd100, 8'd0, 8'd0, 8'd150, 8'd0, 8'd0);

        wr(ADDR_C00, 256);
        wr(ADDR_C01, -256);
        frame_edge(0, 4'd0, 0);
        px_expect("clamp_lo", 8'd50, 8'd100, 8'd0, 8'd0, 8'd100, 8'd0);
        px_expect("diff", 8'd101, 8'd100, 8'd0, 8'd1, 8'd100, 8'd0);
        wr(ADDR_C01, 0);
        wr(ADDR_C00, 129);
        frame_edge(0, 4'd0, 0);
        px_expect("round", 8'd1, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0);
        wr(ADDR_C00, 256);
        frame_edge(0, 4'd0, 0);

        wr(ADDR_C11, 512);
        chk("mid_pending", cfg_pending, 1'b1);
        px_expect("staged", 8'd0, 8'd60, 8'd0, 8'd0, 8'd60, 8'd0);
        frame_edge(0, 4'd0, 0);
        px_expect("c11", 8'd0, 8'd60, 8'd0, 8'd0, 8'd120, 8'd0);
        chk("commit_pending", cfg_pending, 1'b0);

        frame_edge(1, ADDR_C22, 0);
        chk("edge_wr_pending", cfg_pending, 1'b1);
        px_expect("edge_wr_old", 8'd0, 8'd0, 8'd77, 8'd0, 8'd0, 8'd77);
        frame_edge(0, 4'd0, 0);
        px_expect("edge_wr_new", 8'd0, 8'd0, 8'd77, 8'd0, 8'd0, 8'd0);

        for (int f = 0; f < 6; f++) begin
            for (int k = 0; k < 9; k++) wr(4'(k), int'($urandom_range(0, 1279)) - 512);
            wr(ADDR_BYPASS, (f == 5) ? 1 : 0);
            frame_edge(0, 4'd0, 0);
            for (int ln = 0; ln < 3; ln++) begin
                for (int p = 0; p < 16; p++) begin
                    cfg_we    = ($urandom_range(0, 5) == 0);
                    cfg_addr  = 4'($urandom_range(0, 15));
                    cfg_wdata = COEF_W'($urandom);
                    drive(0, p == 0, 1, 8'($urandom), 8'($urandom), 8'($urandom));
                    tick();
                end
                cfg_we = 1'b0;
                idle(2);
            end
        end

        wr(ADDR_BYPASS, 1);
        wr(ADDR_C00, 300);
        wr(ADDR_C12, -100);
        frame_edge(0, 4'd0, 0);
        px_expect("bypass", 8'd33, 8'd200, 8'd7, 8'd33, 8'd200, 8'd7);

        wr(ADDR_BYPASS, 0);
        wr(ADDR_C00, 0);
        for (int p = 0; p < 5; p++) begin
            drive(0, p == 0, 1, 8'($urandom), 8'($urandom), 8'($urandom));
            tick();
        end
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_R", out_data_R, 8'd0);
        chk("midrst_G", out_data_G, 8'd0);
        chk("midrst_B", out_data_B, 8'd0);
        chk("midrst_den", out_den, 1'b0);
        chk("midrst_pending", cfg_pending, 1'b0);
        model_reset();
        tick();
        tick();
        #2 reset_n = 1'b1;
        px_expect("post_rst", 8'd90, 8'd45, 8'd200, 8'd90, 8'd45, 8'd200);
        frame_edge(0, 4'd0, 0);
        px_expect("post_rst_commit", 8'd90, 8'd45, 8'd200, 8'd90, 8'd45, 8'd200);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
